// File: rtl/ddr3_addr_cmd_delay_ctrl_if.sv
// Request/response bundle between the training logic (master) and the
// delay-line controller (slave).
// Handshake: a request transfers on the clock edge where REQ_VALID and REQ_READY
// are both high; REQ_OP/REQ_COUNT must be stable while REQ_VALID is high.
// DONE/ERR are single-cycle pulses with no back-pressure.
interface ddr3_addr_cmd_delay_ctrl_if;
  logic       REQ_VALID;
  logic       REQ_READY;
  logic [1:0] REQ_OP;
  logic [7:0] REQ_COUNT;
  logic       DONE;
  logic       ERR;

  modport master (
    output REQ_VALID, REQ_OP, REQ_COUNT,
    input  REQ_READY, DONE, ERR
  );

  modport slave (
    input  REQ_VALID, REQ_OP, REQ_COUNT,
    output REQ_READY, DONE, ERR
  );
endinterface

// File: rtl/ddr3_addr_cmd_delay_ctrl.sv
// Sequences load/inc/dec requests into paced DELAY_LINE_* strobes, bracketed by
// HS_IO_CLK_PAUSE, and tracks the resulting TX tap setting.
module ddr3_addr_cmd_delay_ctrl #(
  parameter int         MOVE_GAP    = 4,
  parameter int         PAUSE_SETUP = 2,
  parameter int         PAUSE_HOLD  = 2,
  parameter logic [7:0] LOAD_VAL    = 8'd1
) (
  input  logic                         FAB_CLK,
  input  logic                         ARST_N,
  ddr3_addr_cmd_delay_ctrl_if.slave    req,
  output logic [7:0]                   TAP_COUNT,
  output logic                         DELAY_LINE_SEL,
  output logic                         DELAY_LINE_LOAD,
  output logic                         DELAY_LINE_DIRECTION,
  output logic                         DELAY_LINE_MOVE,
  output logic                         HS_IO_CLK_PAUSE,
  input  logic                         TX_DELAY_LINE_OUT_OF_RANGE,
  output logic [2:0]                   state_dbg
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PAUSE_ON  = 3'd1,
    STROBE    = 3'd2,
    GAP       = 3'd3,
    PAUSE_OFF = 3'd4,
    RESP      = 3'd5
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_RSV  = 2'b11;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] moves_q, moves_d;
  logic [1:0] op_q, op_d;
  logic       err_q, err_d;
  logic [7:0] tap_q, tap_d;
  logic       sel_q, sel_d;
  logic       load_q, load_d;
  logic       dir_q, dir_d;
  logic       move_q, move_d;
  logic       pause_q, pause_d;
  logic       done_q, done_d;
  logic       errp_q, errp_d;
  logic       launch;
  logic       sat;
  logic       active;

  assign sat = ((op_q == OP_INC) && (tap_q == 8'hFF)) ||
               ((op_q == OP_DEC) && (tap_q == 8'h00));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    moves_d = moves_q;
    op_d    = op_q;
    err_d   = err_q;
    tap_d   = tap_q;
    launch  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req.REQ_VALID) begin
          op_d = req.REQ_OP;
          if (req.REQ_OP == OP_RSV) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else if ((req.REQ_OP != OP_LOAD) && (req.REQ_COUNT == 8'd0)) begin
            state_d = RESP;
            err_d   = 1'b0;
          end else begin
            state_d = PAUSE_ON;
            cnt_d   = 4'(PAUSE_SETUP - 1);
            err_d   = 1'b0;
            moves_d = (req.REQ_OP == OP_LOAD) ? 8'd1 : req.REQ_COUNT;
          end
        end
      end
      PAUSE_ON: begin
        if (cnt_q == 4'd0) launch = 1'b1;
        else               cnt_d  = cnt_q - 4'd1;
      end
      STROBE: begin
        state_d = GAP;
        cnt_d   = 4'(MOVE_GAP - 1);
      end
      GAP: begin
        // Out-of-range seen on any gap cycle (including the last) stops further moves.
        err_d = err_q | TX_DELAY_LINE_OUT_OF_RANGE;
        if (cnt_q == 4'd0) launch = 1'b1;
        else               cnt_d  = cnt_q - 4'd1;
      end
      PAUSE_OFF: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Decide the next strobe; saturation is checked against the tap already moved.
    if (launch) begin
      if ((moves_q == 8'd0) || err_d) begin
        state_d = PAUSE_OFF;
        cnt_d   = 4'(PAUSE_HOLD - 1);
      end else if (sat) begin
        err_d   = 1'b1;
        state_d = PAUSE_OFF;
        cnt_d   = 4'(PAUSE_HOLD - 1);
      end else begin
        state_d = STROBE;
        moves_d = moves_q - 8'd1;
        case (op_q)
          OP_LOAD: tap_d = LOAD_VAL;
          OP_INC:  tap_d = tap_q + 8'd1;
          OP_DEC:  tap_d = tap_q - 8'd1;
          default: tap_d = tap_q;
        endcase
      end
    end
  end

  // Outputs are registered from the next state so they line up with the state.
  always_comb begin
    active  = (state_d == PAUSE_ON) || (state_d == STROBE) ||
              (state_d == GAP)      || (state_d == PAUSE_OFF);
    pause_d = active;
    dir_d   = active && (op_d == OP_INC);
    sel_d   = (state_d == STROBE);
    load_d  = (state_d == STROBE) && (op_d == OP_LOAD);
    move_d  = (state_d == STROBE) && (op_d != OP_LOAD);
    done_d  = (state_d == RESP);
    errp_d  = (state_d == RESP) && err_d;
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      moves_q <= 8'd0;
      op_q    <= OP_LOAD;
      err_q   <= 1'b0;
      tap_q   <= LOAD_VAL;
      sel_q   <= 1'b0;
      load_q  <= 1'b0;
      dir_q   <= 1'b0;
      move_q  <= 1'b0;
      pause_q <= 1'b0;
      done_q  <= 1'b0;
      errp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      moves_q <= moves_d;
      op_q    <= op_d;
      err_q   <= err_d;
      tap_q   <= tap_d;
      sel_q   <= sel_d;
      load_q  <= load_d;
      dir_q   <= dir_d;
      move_q  <= move_d;
      pause_q <= pause_d;
      done_q  <= done_d;
      errp_q  <= errp_d;
    end
  end

  assign req.REQ_READY        = (state_q == IDLE);
  assign req.DONE             = done_q;
  assign req.ERR              = errp_q;
  assign TAP_COUNT            = tap_q;
  assign DELAY_LINE_SEL       = sel_q;
  assign DELAY_LINE_LOAD      = load_q;
  assign DELAY_LINE_DIRECTION = dir_q;
  assign DELAY_LINE_MOVE      = move_q;
  assign HS_IO_CLK_PAUSE      = pause_q;
  assign state_dbg            = state_q;

endmodule
